// File: rtl/spi_bus_master_if.sv
// spi_bus_master_if: 68000 bus-side and SPI pin bundle for spi_bus_master.
// The slave modport is the SPI block (a bus target); the master modport is
// whatever drives the CPU bus side and watches the SPI pins.
interface spi_bus_master_if;
  logic       spi_sel;
  logic       cpu_as;
  logic       uds;
  logic       lds;
  logic       rw;
  logic [1:0] address;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       data_oe;
  logic       spi_dtack;
  logic       spi_cs;
  logic       spi_sck;
  logic       spi_mosi;
  logic       spi_miso;

  modport slave (
    input  spi_sel, cpu_as, uds, lds, rw, address, data_in, spi_miso,
    output data_out, data_oe, spi_dtack, spi_cs, spi_sck, spi_mosi
  );

  modport master (
    output spi_sel, cpu_as, uds, lds, rw, address, data_in, spi_miso,
    input  data_out, data_oe, spi_dtack, spi_cs, spi_sck, spi_mosi
  );
endinterface

// File: rtl/spi_bus_master.sv
// spi_bus_master: 68000-bus target that shifts a byte out on an SPI mode-0
// port (MSB first) while capturing the MISO byte. Writes to a busy DATA
// register are stretched with wait states rather than rejected.
// Optional feature macro: SPI_AUTO_CS_EN (CS driven low automatically for
// the duration of each transfer, ORed with the CTRL request bit).
module spi_bus_master #(
  parameter int CLK_DIV = 4
) (
  input logic             i_cpu_clk,
  input logic             i_reset_n,
  spi_bus_master_if.slave bus
);

  typedef enum logic {B_IDLE, B_ACK} busState_t;
  typedef enum logic [1:0] {S_IDLE, S_LEAD, S_TRAIL, S_DONE} shiftState_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  busState_t   r_bState, w_bNext;
  shiftState_t r_sState, w_sNext;

  logic [7:0] r_tx;
  logic [7:0] r_rxShift;
  logic [7:0] r_rx;
  logic [7:0] r_dataOut;
  logic [7:0] r_div;
  logic [2:0] r_bitCnt;
  logic       r_sck;
  logic       r_mosi;
  logic       r_csReq;

  logic [7:0] w_readMux;
  logic       w_acc;
  logic       w_busy;
  logic       w_divEnd;
  logic       w_stall;
  logic       w_wrFire;
  logic       w_txLoad;
  logic       w_ctrlWr;
  logic       w_csActive;

  assign w_acc    = bus.spi_sel & ~bus.cpu_as & ~bus.uds;
  assign w_busy   = (r_sState != S_IDLE);
  assign w_divEnd = (r_div == DIV_LAST);
  // A DATA write may land on the DONE clock: the finished byte is retired and
  // the new one loaded on the same edge, so the stall lifts there.
  assign w_stall  = ~bus.rw & (bus.address == 2'd0) & w_busy & (r_sState != S_DONE);
  assign w_txLoad = w_wrFire & (bus.address == 2'd0);
  assign w_ctrlWr = w_wrFire & (bus.address == 2'd1);

`ifdef SPI_AUTO_CS_EN
  assign w_csActive = r_csReq | w_busy;
`else
  assign w_csActive = r_csReq;
`endif

  assign bus.data_oe   = w_acc & bus.rw;
  assign bus.data_out  = r_dataOut;
  assign bus.spi_dtack = (r_bState != B_ACK);
  assign bus.spi_cs    = ~w_csActive;
  assign bus.spi_sck   = r_sck;
  assign bus.spi_mosi  = r_mosi;

  // Register read multiplexer: rx byte, status word, or all-ones filler.
  always_comb begin
    w_readMux = 8'hFF;
    case (bus.address)
      2'd0:    w_readMux = r_rx;
      2'd1:    w_readMux = {6'd0, w_busy, w_csActive};
      default: w_readMux = 8'hFF;
    endcase
  end

  // Bus handshake next state; the write strobe fires only on the acknowledge edge.
  always_comb begin
    w_bNext  = r_bState;
    w_wrFire = 1'b0;
    case (r_bState)
      B_IDLE: begin
        if (w_acc && !w_stall) begin
          w_bNext  = B_ACK;
          w_wrFire = ~bus.rw;
        end
      end
      B_ACK: begin
        if (bus.cpu_as) begin
          w_bNext = B_IDLE;
        end
      end
      default: w_bNext = B_IDLE;
    endcase
  end

  // Shift sequencer next state: alternating SCK-low and SCK-high halves per bit.
  always_comb begin
    w_sNext = r_sState;
    case (r_sState)
      S_IDLE:  if (w_txLoad) w_sNext = S_LEAD;
      S_LEAD:  if (w_divEnd) w_sNext = S_TRAIL;
      S_TRAIL: if (w_divEnd) w_sNext = (r_bitCnt == 3'd0) ? S_DONE : S_LEAD;
      S_DONE:  w_sNext = w_txLoad ? S_LEAD : S_IDLE;
      default: w_sNext = S_IDLE;
    endcase
  end

  // State registers for both FSMs.
  always_ff @(posedge i_cpu_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_bState <= B_IDLE;
      r_sState <= S_IDLE;
    end else begin
      r_bState <= w_bNext;
      r_sState <= w_sNext;
    end
  end

  // Datapath: divider, SCK/MOSI generation, MISO capture, CTRL and read latch.
  always_ff @(posedge i_cpu_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_tx      <= 8'h00;
      r_rxShift <= 8'h00;
      r_rx      <= 8'h00;
      r_dataOut <= 8'h00;
      r_div     <= 8'h00;
      r_bitCnt  <= 3'd0;
      r_sck     <= 1'b0;
      r_mosi    <= 1'b0;
      r_csReq   <= 1'b0;
    end else begin
      if (w_txLoad) begin
        r_tx     <= bus.data_in;
        r_mosi   <= bus.data_in[7];
        r_bitCnt <= 3'd7;
        r_div    <= 8'h00;
      end else begin
        case (r_sState)
          S_LEAD: begin
            if (w_divEnd) begin
              r_sck     <= 1'b1;
              r_rxShift <= {r_rxShift[6:0], bus.spi_miso};
              r_div     <= 8'h00;
            end else begin
              r_div <= r_div + 8'd1;
            end
          end
          S_TRAIL: begin
            if (w_divEnd) begin
              r_sck <= 1'b0;
              r_div <= 8'h00;
              if (r_bitCnt != 3'd0) begin
                r_bitCnt <= r_bitCnt - 3'd1;
                r_tx     <= {r_tx[6:0], 1'b0};
                r_mosi   <= r_tx[6];
              end
            end else begin
              r_div <= r_div + 8'd1;
            end
          end
          default: ;
        endcase
      end
      if (r_sState == S_DONE) begin
        r_rx <= r_rxShift;
      end
      if (w_ctrlWr) begin
        r_csReq <= bus.data_in[0];
      end
      if ((r_bState == B_IDLE) && w_acc) begin
        r_dataOut <= w_readMux;
      end
    end
  end

endmodule

// File: tb/tb_spi_bus_master.sv
// tb_spi_bus_master: directed bench for spi_bus_master with a cycle-count
// timeline model of the SPI transfer and bus handshake, checked every clock.
module tb_spi_bus_master;

  localparam int D = 4;
`ifdef SPI_AUTO_CS_EN
  localparam bit AUTO_CS = 1'b1;
`else
  localparam bit AUTO_CS = 1'b0;
`endif

  logic clk;
  logic rstN;
  logic misoHigh;
  spi_bus_master_if bus();

  spi_bus_master #(.CLK_DIV(D)) dut (
    .i_cpu_clk(clk),
    .i_reset_n(rstN),
    .bus(bus)
  );

  assign bus.spi_miso = misoHigh ? 1'b1 : bus.spi_mosi;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int totalCount = 0;
  int badCount = 0;
  int cyc = 0;
  bit checkEn = 1'b0;
  bit countCs = 1'b0;
  int csLowCount = 0;
  bit recordEn = 1'b0;
  int riseCyc[$];
  logic riseMosi[$];

  // Model state: mK = clocks since the load edge (-1 when no transfer).
  int mK;
  logic [7:0] mTx, mRxShift, mRx, mDataOut, mMux;
  logic mAck, mCsReq, mAcc, mBusyPre, mCsPre, mLoad, mBit;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalCount++;
    if (act !== exp) begin
      badCount++;
      $display("[TB] FAIL %s: got %0h want %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One 68000 bus cycle: strobe, wait (bounded) for DTACK, capture data, release.
  task automatic applyStimulus(input bit isRead, input logic [1:0] addr, input logic [7:0] wdata,
                               input int maxWait, output logic [7:0] rdata, output int waits);
    @(negedge clk);
    bus.spi_sel = 1'b1; bus.cpu_as = 1'b0; bus.uds = 1'b0; bus.lds = 1'b0;
    bus.rw = isRead; bus.address = addr; bus.data_in = wdata;
    waits = 0;
    do begin
      @(negedge clk);
      waits++;
    end while (bus.spi_dtack !== 1'b0 && waits < maxWait);
    if (bus.spi_dtack !== 1'b0) checkOutput("dtackTimeout", bus.spi_dtack, 0);
    rdata = bus.data_out;
    bus.spi_sel = 1'b0; bus.cpu_as = 1'b1; bus.uds = 1'b1; bus.lds = 1'b1; bus.rw = 1'b1;
    @(negedge clk);
  endtask

  always @(posedge clk) cyc++;

  always @(posedge bus.spi_sck) begin
    if (recordEn) begin
      riseCyc.push_back(cyc);
      riseMosi.push_back(bus.spi_mosi);
    end
  end

  function automatic logic expMosi(input int k, input logic [7:0] tx);
    if (k >= 0 && k < 16 * D) return tx[7 - (k / D) / 2];
    return tx[0];
  endfunction

  // Behavioural model: advances one clock per edge from the driven bus inputs.
  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      mK = -1; mTx = 8'h00; mRxShift = 8'h00; mRx = 8'h00; mDataOut = 8'h00;
      mAck = 1'b0; mCsReq = 1'b0;
    end else begin
      mAcc = bus.spi_sel & ~bus.cpu_as & ~bus.uds;
      mBusyPre = (mK >= 0);
      mCsPre = mCsReq | (AUTO_CS & mBusyPre);
      if (bus.address == 2'd0) mMux = mRx;
      else if (bus.address == 2'd1) mMux = {6'd0, mBusyPre, mCsPre};
      else mMux = 8'hFF;
      mLoad = 1'b0;
      if (!mAck) begin
        if (mAcc) begin
          mDataOut = mMux;
          if (!(!bus.rw && bus.address == 2'd0 && mBusyPre && mK != 16 * D)) begin
            mAck = 1'b1;
            if (!bus.rw && bus.address == 2'd0) mLoad = 1'b1;
            if (!bus.rw && bus.address == 2'd1) mCsReq = bus.data_in[0];
          end
        end
      end else if (bus.cpu_as) begin
        mAck = 1'b0;
      end
      if (mK >= 0 && mK < 16 * D && (mK % (2 * D)) == D - 1) begin
        mBit = misoHigh ? 1'b1 : expMosi(mK, mTx);
        mRxShift = {mRxShift[6:0], mBit};
      end
      if (mK == 16 * D) begin
        mRx = mRxShift;
        mK = -1;
      end else if (mK >= 0) begin
        mK++;
      end
      if (mLoad) begin
        mTx = bus.data_in;
        mK = 0;
      end
    end
  end

  // Compare process: all outputs against the model, just after every edge.
  always @(posedge clk) begin
    #1;
    if (checkEn) begin
      checkOutput("dtack", bus.spi_dtack, !mAck);
      checkOutput("sck", bus.spi_sck, (mK >= 0 && mK < 16 * D) ? ((mK / D) % 2) : 0);
      checkOutput("mosi", bus.spi_mosi, expMosi(mK, mTx));
      checkOutput("cs", bus.spi_cs, !(mCsReq | (AUTO_CS & (mK >= 0))));
      checkOutput("dataOe", bus.data_oe, bus.spi_sel & ~bus.cpu_as & ~bus.uds & bus.rw);
      checkOutput("dataOut", bus.data_out, mDataOut);
    end
    if (countCs && bus.spi_cs === 1'b0) csLowCount++;
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] rd;
    logic [7:0] pattern;
    int w;
    int maxGap;
    rstN = 1'b0; misoHigh = 1'b0;
    bus.spi_sel = 1'b0; bus.cpu_as = 1'b1; bus.uds = 1'b1; bus.lds = 1'b1;
    bus.rw = 1'b1; bus.address = 2'd0; bus.data_in = 8'h00;
    waitCycles(3);
    checkEn = 1'b1;
    waitCycles(2);
    rstN = 1'b1;
    $display("[TB] reset released");

    applyStimulus(1, 2'd1, 8'h00, 20, rd, w);
    checkOutput("statAfterReset", rd, 8'h00);

    // Test 2: CS on, 0xA5 looped back, SCK period and MOSI order.
    applyStimulus(0, 2'd1, 8'h01, 20, rd, w);
    riseCyc.delete(); riseMosi.delete(); recordEn = 1'b1;
    applyStimulus(0, 2'd0, 8'hA5, 20, rd, w);
    waitCycles(70);
    recordEn = 1'b0;
    checkOutput("t2Pulses", riseCyc.size(), 8);
    for (int i = 1; i < riseCyc.size(); i++) checkOutput("t2Period", riseCyc[i] - riseCyc[i-1], 8);
    pattern = 8'hA5;
    for (int i = 0; i < riseMosi.size() && i < 8; i++) checkOutput("t2Mosi", riseMosi[i], pattern[7-i]);
    applyStimulus(1, 2'd1, 8'h00, 20, rd, w);
    checkOutput("t2StatIdle", rd, 8'h01);
    applyStimulus(1, 2'd0, 8'h00, 20, rd, w);
    checkOutput("t2Rx", rd, 8'hA5);
    applyStimulus(0, 2'd1, 8'h00, 20, rd, w);

    // Test 3: MISO tied high, busy visible in STAT.
    misoHigh = 1'b1;
    applyStimulus(0, 2'd0, 8'h00, 20, rd, w);
    applyStimulus(1, 2'd1, 8'h00, 20, rd, w);
    checkOutput("t3StatBusy", rd, AUTO_CS ? 8'h03 : 8'h02);
    waitCycles(70);
    applyStimulus(1, 2'd1, 8'h00, 20, rd, w);
    checkOutput("t3StatDone", rd, 8'h00);
    applyStimulus(1, 2'd0, 8'h00, 20, rd, w);
    checkOutput("t3Rx", rd, 8'hFF);
    misoHigh = 1'b0;

    // Test 4: back-to-back writes, second one stalls until DONE.
    riseCyc.delete(); riseMosi.delete(); recordEn = 1'b1;
    applyStimulus(0, 2'd0, 8'h3C, 20, rd, w);
    applyStimulus(0, 2'd0, 8'hC3, 200, rd, w);
    checkOutput("t4Stalled", (w > 50), 1);
    waitCycles(80);
    recordEn = 1'b0;
    checkOutput("t4Pulses", riseCyc.size(), 16);
    maxGap = 0;
    for (int i = 1; i < riseCyc.size(); i++)
      if (riseCyc[i] - riseCyc[i-1] > maxGap) maxGap = riseCyc[i] - riseCyc[i-1];
    checkOutput("t4MaxGap", maxGap, 9);
    applyStimulus(1, 2'd0, 8'h00, 20, rd, w);
    checkOutput("t4Rx", rd, 8'hC3);

    // Test 5: reads during busy are not stalled and return the old byte.
    applyStimulus(0, 2'd0, 8'h5A, 20, rd, w);
    applyStimulus(1, 2'd0, 8'h00, 20, rd, w);
    checkOutput("t5OldRx", rd, 8'hC3);
    checkOutput("t5ReadWaits", w, 1);
    applyStimulus(1, 2'd2, 8'h00, 20, rd, w);
    checkOutput("t5Off2", rd, 8'hFF);
    applyStimulus(1, 2'd3, 8'h00, 20, rd, w);
    checkOutput("t5Off3", rd, 8'hFF);
    waitCycles(70);
    applyStimulus(1, 2'd0, 8'h00, 20, rd, w);
    checkOutput("t5NewRx", rd, 8'h5A);

    // Test 6: CS behaviour with CTRL cleared.
    csLowCount = 0; countCs = 1'b1;
    applyStimulus(0, 2'd0, 8'h55, 20, rd, w);
    waitCycles(80);
    countCs = 1'b0;
    checkOutput("t6CsLowClocks", csLowCount, AUTO_CS ? 65 : 0);
    applyStimulus(1, 2'd0, 8'h00, 20, rd, w);
    checkOutput("t6Rx", rd, 8'h55);

    // Test 1: reset at bit 4 of a transfer.
    riseCyc.delete(); riseMosi.delete(); recordEn = 1'b1;
    applyStimulus(0, 2'd0, 8'h96, 20, rd, w);
    w = 0;
    while (riseCyc.size() < 4 && w < 200) begin
      @(negedge clk);
      w++;
    end
    checkOutput("t1ReachedBit4", (riseCyc.size() >= 4), 1);
    recordEn = 1'b0;
    rstN = 1'b0;
    #1;
    checkOutput("t1Sck", bus.spi_sck, 0);
    checkOutput("t1Cs", bus.spi_cs, 1);
    checkOutput("t1Dtack", bus.spi_dtack, 1);
    waitCycles(3);
    rstN = 1'b1;
    applyStimulus(1, 2'd1, 8'h00, 20, rd, w);
    checkOutput("t1Stat", rd, 8'h00);
    applyStimulus(1, 2'd0, 8'h00, 20, rd, w);
    checkOutput("t1Rx", rd, 8'h00);
    waitCycles(5);

    $display("test done: total=%0d bad=%0d", totalCount, badCount);
    $finish;
  end

endmodule
